// File: rtl/sigma_delta_dac.sv
// rtl/sigma_delta_dac.sv - first-order delta-sigma DAC, unsigned sample to 1-bit pulse density
//
// Ports:
//   clk_i    in   1       system clock, rising edge
//   res_n_i  in   1       synchronous active-low reset
//   dac_i    in   C_bits  unsigned sample, 0 = minimum, 2^C_bits-1 = maximum
//   dac_o    out  1       registered pulse-density output (feeds external RC filter)
//
// Optional feature: define SIGMA_DELTA_DAC_DITHER_EN to add a 16-bit LFSR whose
// bit 0 is injected as an extra carry into the sigma accumulator.

module sigma_delta_dac #(
    parameter int C_bits = 16
) (
    input  logic              clk_i,
    input  logic              res_n_i,
    input  logic [C_bits-1:0] dac_i,
    output logic              dac_o
);

    localparam int W = C_bits;

    logic [W-1:0] r_x;
    logic [W+1:0] r_sigma;
    logic         r_dac;

    logic [W+1:0] w_delta;
    logic [W+1:0] w_sigma_next;

    // Feedback: the top bit of sigma acts as the 1-bit quantiser. When set,
    // adding 3*2^W modulo 2^(W+2) subtracts one full-scale step.
    assign w_delta = {r_sigma[W+1], r_sigma[W+1], {W{1'b0}}};

`ifdef SIGMA_DELTA_DAC_DITHER_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Fibonacci taps 16,14,13,11 map to bit indices 15,13,12,10
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_sigma_next = r_sigma + w_delta + {2'b00, r_x} + {{(W+1){1'b0}}, r_lfsr[0]};
`else
    assign w_sigma_next = r_sigma + w_delta + {2'b00, r_x};
`endif

    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            r_x     <= '0;
            r_sigma <= {2'b01, {W{1'b0}}};
            r_dac   <= 1'b0;
        end else begin
            r_x     <= dac_i;
            r_sigma <= w_sigma_next;
            r_dac   <= r_sigma[W+1];
        end
    end

    assign dac_o = r_dac;

endmodule

// File: tb/tb_sigma_delta_dac.sv
// tb/tb_sigma_delta_dac.sv - self-checking bench for sigma_delta_dac (C_bits=4 and C_bits=16)

module tb_sigma_delta_dac;

    logic        clk = 1'b0;
    logic        rn4;
    logic        rn16;
    logic [3:0]  d4;
    logic [15:0] d16;
    logic        o4;
    logic        o16;

    always #5 clk = ~clk;

    sigma_delta_dac #(.C_bits(4)) u_dut4 (
        .clk_i   (clk),
        .res_n_i (rn4),
        .dac_i   (d4),
        .dac_o   (o4)
    );

    sigma_delta_dac #(.C_bits(16)) u_dut16 (
        .clk_i   (clk),
        .res_n_i (rn16),
        .dac_i   (d16),
        .dac_o   (o16)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    bit q4[$];
    bit q16[$];

    int s4, x4, s16, x16;
    bit last4, last16;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        tests_run++;
        assert (obs >= lo && obs <= hi) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Reference behaviour in plain integer arithmetic
    task automatic model(input int w, input bit rn, input int d,
                         inout int s, inout int x, output bit o);
        int full;
        int delta;
        full = 1 << w;
        if (!rn) begin
            s = full;
            x = 0;
            o = 1'b0;
        end else begin
            o     = (s >= 2 * full);
            delta = o ? 3 * full : 0;
            s     = (s + delta + x) % (4 * full);
            x     = d;
        end
    endtask

    // Drive one cycle on both DUTs: model predicts, pushes, then the DUT output is popped and compared
    task automatic step(input bit r4, input int v4, input bit r16, input int v16);
        bit e;
        logic [31:0] v4l;
        logic [31:0] v16l;
        v4l  = v4;
        v16l = v16;
        @(negedge clk);
        rn4  = r4;
        d4   = v4l[3:0];
        rn16 = r16;
        d16  = v16l[15:0];
        model(4, r4, v4, s4, x4, e);
        q4.push_back(e);
        model(16, r16, v16, s16, x16, e);
        q16.push_back(e);
        @(posedge clk);
        #1;
        check("dac4", {31'd0, o4}, {31'd0, q4.pop_front()});
        check("dac16", {31'd0, o16}, {31'd0, q16.pop_front()});
        last4  = o4;
        last16 = o16;
    endtask

    initial begin
        int ones;
        int win;
        int ones16;
        bit prev;
        int codes[5];
        bit seq_a[40];

        codes = '{1, 3, 5, 13, 15};
        rn4 = 1'b0; rn16 = 1'b0; d4 = '0; d16 = 16'hFFFF;
        s4 = 16; x4 = 0; s16 = 1 << 16; x16 = 0;

        // Reset held with full-scale input on the 16-bit instance
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 'hFFFF);
            check("rst_o16", {31'd0, o16}, 32'd0);
        end
        check("rst_sigma16", {14'd0, u_dut16.r_sigma}, 32'h10000);

        // Zero input, 200 cycles
        ones = 0;
        for (int i = 0; i < 200; i++) begin
            step(1, 0, 1, 'h4000);
            ones += int'(last4);
        end
        check("zero_ones", ones, 0);
        check("zero_sigma4", {26'd0, u_dut4.r_sigma}, 32'd16);

        // Half scale: three settling cycles, then strict alternation
        for (int i = 0; i < 3; i++) step(1, 8, 1, 'h4000);
        for (int w = 0; w < 2; w++) begin
            ones = 0;
            for (int i = 0; i < 16; i++) begin
                prev = last4;
                step(1, 8, 1, 'h4000);
                ones += int'(last4);
                check("half_alt", {31'd0, last4}, {31'd0, ~prev});
            end
            check("half_window", ones, 8);
        end

        // Arbitrary codes, 64 cycles each; windows taken over the last 48 cycles
        foreach (codes[k]) begin
            ones = 0;
            win  = 0;
            for (int i = 0; i < 64; i++) begin
                step(1, codes[k], 1, 'h4000);
                if (i >= 16) begin
                    ones += int'(last4);
                    win  += int'(last4);
                    if ((i % 16) == 15) begin
                        check_range("code_window", win, codes[k] - 1, codes[k] + 1);
                        win = 0;
                    end
                end
            end
            check_range("code_total48", ones, 3 * codes[k] - 1, 3 * codes[k] + 1);
        end

        // Fresh reset then record the post-reset reference sequence at code 11
        step(0, 11, 1, 'h4000);
        check("fresh_rst_o", {31'd0, last4}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            step(1, 11, 1, 'h4000);
            seq_a[i] = last4;
        end
        for (int i = 0; i < 20; i++) step(1, 11, 1, 'h4000);

        // Mid-stream one-cycle reset pulse
        step(0, 11, 1, 'h4000);
        check("mid_rst_o", {31'd0, last4}, 32'd0);
        check("mid_rst_sigma", {26'd0, u_dut4.r_sigma}, 32'd16);
        for (int i = 0; i < 40; i++) begin
            step(1, 11, 1, 'h4000);
            check("mid_seq", {31'd0, last4}, {31'd0, seq_a[i]});
        end

        // 16-bit quarter scale density over 4096 cycles
        ones16 = 0;
        for (int i = 0; i < 4096; i++) begin
            step(1, 5, 1, 'h4000);
            ones16 += int'(last16);
        end
        check_range("w16_quarter", ones16, 1024 - 2, 1024 + 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
